// File: rtl/stream_demux_1x4_nbit.sv
// Registered 1-to-4 valid/ready stream demultiplexer.
// Each output channel owns a one-word slot; pending counts the full slots.
module stream_demux_1x4_nbit #(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [n-1:0] in_data,
  input  logic [1:0]   in_sel,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [n-1:0] out_a,
  output logic [n-1:0] out_b,
  output logic [n-1:0] out_c,
  output logic [n-1:0] out_d,
  output logic [3:0]   out_valid,
  input  logic [3:0]   out_ready,
  output logic [2:0]   pending
);

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    popcount4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  logic [3:0]   full_r;
  logic [n-1:0] slot_r [4];
  logic [2:0]   pending_r;
  logic [3:0]   sel_hot_s;
  logic [3:0]   accept_s;
  logic [3:0]   drain_s;
  logic [3:0]   full_next_s;

  // Decode accept and drains; a drained slot may refill on the same edge.
  always_comb begin
    sel_hot_s = 4'b0000;
    case (in_sel)
      2'd0:    sel_hot_s = 4'b0001;
      2'd1:    sel_hot_s = 4'b0010;
      2'd2:    sel_hot_s = 4'b0100;
      2'd3:    sel_hot_s = 4'b1000;
      default: sel_hot_s = 4'b0000;
    endcase
    in_ready = ~full_r[in_sel] | out_ready[in_sel];
    if (in_valid && in_ready) begin
      accept_s = sel_hot_s;
    end else begin
      accept_s = 4'b0000;
    end
    drain_s     = full_r & out_ready;
    full_next_s = (full_r & ~drain_s) | accept_s;
  end

  // Slot full flags and registered occupancy count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_r    <= 4'b0000;
      pending_r <= 3'd0;
    end else begin
      full_r    <= full_next_s;
      pending_r <= popcount4(full_next_s);
    end
  end

  // Slot data registers load only on accept, so empty slots keep their value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        slot_r[i] <= {n{1'b0}};
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (accept_s[i]) begin
          slot_r[i] <= in_data;
        end
      end
    end
  end

  assign out_a     = slot_r[0];
  assign out_b     = slot_r[1];
  assign out_c     = slot_r[2];
  assign out_d     = slot_r[3];
  assign out_valid = full_r;
  assign pending   = pending_r;

endmodule

// File: doc/stream_demux_1x4_nbit.md
# stream_demux_1x4_nbit

Registered 1-to-4 stream demultiplexer: the distributing counterpart of the team's 4x1 n-bit multiplexer. It accepts one n-bit word per cycle on a valid/ready input and routes it by a 2-bit select into one of four output channels. Each output channel holds one word in its own register until the downstream consumer takes it. The block sits between a single producer and four independent consumers, and provides per-channel backpressure and a live occupancy count.

## Interface
- n, 4, data width in bits (n >= 1)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_data  input  n  word to route
- in_sel  input  2  destination channel: 00 -> A, 01 -> B, 10 -> C, 11 -> D
- in_valid  input  1  producer has a word on in_data/in_sel
- in_ready  output  1  block can accept a word for the currently selected channel
- out_a, out_b, out_c, out_d  output  n each  registered channel data
- out_valid  output  4  bit 0 = A, bit 1 = B, bit 2 = C, bit 3 = D; channel register holds a word
- out_ready  input  4  per-channel consumer accept, same bit order as out_valid
- pending  output  3  number of full channel registers, 0..4

## Operation
- Four channel slots. Each slot is a data register plus a full flag. out_valid[i] is the full flag. out_x is the slot data register.
- in_ready = ~out_valid[in_sel] | out_ready[in_sel]. It is combinational, evaluated whether or not in_valid is asserted, and does not depend on the other three channels.
- Accept condition: in_valid & in_ready at a rising clk edge. On acceptance:
  - the slot in_sel captures in_data;
  - the slot's full flag is set.
- Drain condition for slot i: out_valid[i] & out_ready[i] at a rising edge. On drain, slot i clears its full flag unless the same edge also accepts a word into slot i.
- Simultaneous drain and accept on the same slot: the new word replaces the old one and the full flag stays 1, so the channel streams at full rate.
- Draining a non-selected slot in the same cycle as an accept is independent. Up to one accept and up to four drains can occur per edge.
- out_x data is held unchanged while its slot is full and not drained. Data in an empty slot is don't-care but must not change except on an accept; the bench checks this.
- pending = popcount(out_valid) as a registered value. It updates on the same edge as the flags and is never a combinational sum of out_ready.
- in_sel and in_data are ignored when in_valid = 0. out_ready bits are ignored for empty slots.
- No data reordering within a channel. No word is ever duplicated or dropped once accepted.

## Timing
- Reset (rst = 1, asynchronous, effective immediately without a clock):
  - out_valid = 4'b0000;
  - pending = 0;
  - out_a..out_d = {n{1'b0}};
  - in_ready therefore reads 1 for any in_sel.
- Reset asserted mid-operation discards all held words. After release, the first edge with in_valid = 1 is accepted normally.
- Latency: a word accepted at edge k appears on out_x with out_valid = 1 after edge k. The earliest the consumer can take it is edge k+1.
- Throughput per channel: one word per cycle while out_ready stays high. Across channels, one word per cycle is accepted in total.
- Full slot with out_ready low: in_ready = 0 for that in_sel. The producer must hold in_data/in_sel/in_valid stable until acceptance. Changing in_sel to a free channel is permitted and is accepted on that edge.
- pending wrap: the value never exceeds 4 and never underflows below 0, including the case of 4 simultaneous drains plus 1 accept (4 -> 1).

## Test plan
- Reset check: assert rst mid-stream with all 4 slots full. Required response, without a clock edge: out_valid = 0000, pending = 0, out_a..d = 0, in_ready = 1.
- Routing: send 0x3 to sel 00, 0x5 to 01, 0xA to 10, 0xF to 11 on consecutive edges with out_ready = 0000. Required response: out_a = 3, out_b = 5, out_c = A, out_d = F; out_valid = 1111; pending steps 1, 2, 3, 4.
- Backpressure: slot B full with out_ready[1] = 0, in_valid = 1, in_sel = 01, data 0x7. Required response: in_ready = 0 and out_b keeps its old value over 5 cycles. Then raise out_ready[1]: 0x7 is accepted on that edge and out_b = 7 on the next cycle.
- Streaming: in_sel = 10, out_ready[2] = 1, data 1, 2, 3, 4 on back-to-back edges. Required response: in_ready stays 1; out_c shows 1, 2, 3, 4 one cycle later; out_valid[2] stays 1; pending stays 1.
- Simultaneous events: pending = 4, out_ready = 1111, and an accept to sel 00 of 0x9 on the same edge. Required response: pending = 1, out_valid = 0001, out_a = 9.
- Idle select: in_valid = 0 with in_sel toggling and in_data random for 10 cycles. Required response: no slot data or flag changes; pending is unchanged.
